pipelined_barrel_shifter: RTL and testbench

- Multi-function barrel shifter for a 2**N-bit word: logical left, logical right, arithmetic right, rotate right.
- Fully pipelined with one register stage per shift-amount bit, so each stage shifts by 0 or 2**k.
- Valid/ready handshake on input and output, with whole-pipeline stall on backpressure.
- Replaces the combinational left/right select path in the datapath wherever shifts need to meet timing at full clock rate.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 21 ++
 rtl/pipelined_barrel_shifter_stage.sv | 63 ++++++
 rtl/pipelined_barrel_shifter.sv | 106 ++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
//
// Contents:
//   shift_op_t : shift operation select, encoded exactly as on the in_op port
//                (00 LSL, 01 LSR, 10 ASR, 11 ROR).
//   DEFAULT_N  : default log2 of the datapath width.
//
// The per-stage payload struct depends on the data width, so it is declared
// inside the top module where that width is known.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  localparam int DEFAULT_N = 3;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One stage of the pipelined barrel shifter: purely combinational.
// Shifts or rotates by SHIFT positions when en is set, otherwise passes the
// word through unchanged.
//
// Parameters:
//   W     : data width
//   SHIFT : fixed shift distance of this stage (a power of two below W)
//
// Ports:
//   en        in  1  this stage's shift-amount bit
//   op        in  2  operation select (shift_op_t)
//   data_in   in  W  word entering the stage
//   carry_in  in  1  carry from earlier stages
//   data_out  out W  word leaving the stage
//   carry_out out 1  last bit shifted or rotated out so far
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int W     = 8,
  parameter int SHIFT = 1
) (
  input  logic         en,
  input  shift_op_t    op,
  input  logic [W-1:0] data_in,
  input  logic         carry_in,
  output logic [W-1:0] data_out,
  output logic         carry_out
);

  // Earlier stages only ever apply smaller distances, so the bit picked here
  // is also the last bit shifted out of the original word overall.
  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    if (en) begin
      case (op)
        OP_LSL: begin
          data_out  = data_in << SHIFT;
          carry_out = data_in[W-SHIFT];
        end
        OP_LSR: begin
          data_out  = data_in >> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        OP_ASR: begin
          // The MSB still holds the original sign, because every earlier
          // stage replicates it.
          data_out  = $signed(data_in) >>> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        OP_ROR: begin
          data_out  = (data_in >> SHIFT) | (data_in << (W - SHIFT));
          carry_out = data_in[SHIFT-1];
        end
        default: begin
          data_out  = data_in;
          carry_out = carry_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-function barrel shifter for a 2**N-bit word.
// There is one register stage per shift-amount bit. Stage k applies the shift
// for amt[k], either 0 or 2**k positions.
// A valid/ready handshake is used on both sides. Backpressure freezes the
// whole pipeline.
//
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   in_valid  in  1  input word valid
//   in_ready  out 1  input accepted this cycle when in_valid is high
//   in_data   in  W  operand
//   in_amt    in  N  shift amount 0..W-1
//   in_op     in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid out 1  result valid
//   out_ready in  1  consumer accepts result
//   out_data  out W  shifted result
//   out_carry out 1  last bit shifted or rotated out (0 when amount is 0)
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [(1<<N)-1:0]   in_data,
  input  logic [N-1:0]        in_amt,
  input  logic [1:0]          in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<N)-1:0]   out_data,
  output logic                out_carry
);

  localparam int W = 1 << N;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  data;
    logic [N-1:0]  amt;
    shift_op_t     op;
    logic          carry;
  } stage_t;

  stage_t stg_q [N];
  stage_t stg_d [N];
  stage_t in_payload;
  logic   adv;

  // The whole pipeline moves together. Because bubbles are not squeezed out,
  // the only condition that stops it is an unaccepted result at the tail.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  assign in_payload = '{valid: in_valid, data: in_data, amt: in_amt,
                        op: shift_op_t'(in_op), carry: 1'b0};

  for (genvar k = 0; k < N; k++) begin : g_stage
    stage_t        stage_in;
    logic [W-1:0]  shifted;
    logic          shifted_carry;

    if (k == 0) begin : g_first
      assign stage_in = in_payload;
    end else begin : g_next
      assign stage_in = stg_q[k-1];
    end

    barrel_shift_stage #(
      .W     (W),
      .SHIFT (1 << k)
    ) u_stage (
      .en        (stage_in.amt[k]),
      .op        (stage_in.op),
      .data_in   (stage_in.data),
      .carry_in  (stage_in.carry),
      .data_out  (shifted),
      .carry_out (shifted_carry)
    );

    assign stg_d[k] = '{valid: stage_in.valid, data: shifted,
                        amt: stage_in.amt, op: stage_in.op,
                        carry: shifted_carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stg_q[i] <= '0;
      end
    end else if (adv) begin
      stg_q <= stg_d;
    end
  end

  assign out_valid = stg_q[N-1].valid;
  assign out_data  = stg_q[N-1].data;
  assign out_carry = stg_q[N-1].carry;

  // The final stage's amount and op are only needed by earlier stages.
  logic unused_tail;
  assign unused_tail = ^{stg_q[N-1].amt, stg_q[N-1].op};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=3, W=8).
module tb_pipelined_barrel_shifter;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_amt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_carry;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
  } exp_t;

  exp_t expq[$];

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  // Reference: whole-word arithmetic on the original operand.
  function automatic void ref_model(input logic [7:0] d, input int a,
                                    input logic [1:0] op,
                                    output logic [7:0] r, output logic c);
    logic [15:0] wide;
    case (op)
      2'd0: begin wide = 16'(d) << a; r = wide[7:0]; end
      2'd1: r = d >> a;
      2'd2: r = (d >> a) | (d[7] ? ~(8'hFF >> a) : 8'h00);
      default: begin wide = {d, d} >> a; r = wide[7:0]; end
    endcase
    if (a == 0) c = 1'b0;
    else if (op == 2'd0) c = d[8-a];
    else c = d[a-1];
  endfunction

  task automatic send_one(input logic [7:0] d, input logic [2:0] a,
                          input logic [1:0] op, input logic [7:0] exp_d,
                          input logic exp_c, input string name);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== N) $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cyc, N);
    else passes++;
    checks++;
    if (out_data !== exp_d) $display("[TB] FAIL %s data: got %h, expected %h", name, out_data, exp_d);
    else passes++;
    checks++;
    if (out_carry !== exp_c) $display("[TB] FAIL %s carry: got %b, expected %b", name, out_carry, exp_c);
    else passes++;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b, expected 0", out_valid);
    else passes++;
    checks++;
    if (out_data !== 8'h00) $display("[TB] FAIL reset out_data: got %h, expected 00", out_data);
    else passes++;
    checks++;
    if (out_carry !== 1'b0) $display("[TB] FAIL reset out_carry: got %b, expected 0", out_carry);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b, expected 1", in_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    send_one(8'h81, 3'd1, 2'd0, 8'h02, 1'b1, "lsl_81_1");
    send_one(8'h80, 3'd3, 2'd2, 8'hF0, 1'b0, "asr_80_3");
    send_one(8'h01, 3'd1, 2'd3, 8'h80, 1'b1, "ror_01_1");
    send_one(8'hFF, 3'd7, 2'd1, 8'h01, 1'b1, "lsr_ff_7");
  endtask

  task automatic test_amt_zero();
    for (int op = 0; op < 4; op++) begin
      send_one(8'hA5, 3'd0, 2'(op), 8'hA5, 1'b0, $sformatf("amt0_op%0d", op));
    end
  endtask

  task automatic test_random_single();
    logic [7:0] d, r;
    logic [2:0] a;
    logic [1:0] op;
    logic       c;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      a  = 3'($urandom_range(0, 7));
      op = 2'($urandom_range(0, 3));
      ref_model(d, int'(a), op, r, c);
      send_one(d, a, op, r, c, $sformatf("rand_single%0d", i));
    end
  endtask

  // Streams n_words through while shaping out_ready. In pattern mode
  // out_ready goes 1,0,0,1,0,0,... and the source never idles.
  task automatic run_stream(input int n_words, input bit random_mode, input string name);
    logic [7:0] wd [64];
    logic [2:0] wa [64];
    logic [1:0] wo [64];
    logic [7:0] held_d, r;
    logic       held_c, c, stalled, accepted;
    int sent, got, cyc, extra;
    exp_t e;
    for (int i = 0; i < n_words; i++) begin
      wd[i] = 8'($urandom);
      wa[i] = 3'($urandom_range(0, 7));
      wo[i] = 2'($urandom_range(0, 3));
    end
    expq.delete();
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; accepted = 1'b0;
    held_d = '0; held_c = 1'b0;
    while (got < n_words && cyc < 400) begin
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
      out_ready = random_mode ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      if (!in_valid && sent < n_words && (!random_mode || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = wd[sent];
        in_amt   = wa[sent];
        in_op    = wo[sent];
      end
      #1;
      checks++;
      if (in_ready !== (out_ready | ~out_valid))
        $display("[TB] FAIL %s in_ready cyc %0d: got %b, expected %b", name, cyc, in_ready, out_ready | ~out_valid);
      else passes++;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_carry !== held_c)
          $display("[TB] FAIL %s stall hold cyc %0d: got v%b %h/%b, expected v1 %h/%b",
                   name, cyc, out_valid, out_data, out_carry, held_d, held_c);
        else passes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          $display("[TB] FAIL %s unexpected output: got %h, expected none", name, out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.data || out_carry !== e.carry)
            $display("[TB] FAIL %s result %0d: got %h/%b, expected %h/%b",
                     name, got, out_data, out_carry, e.data, e.carry);
          else passes++;
        end
        got++;
      end
      stalled = out_valid & ~out_ready;
      held_d  = out_data;
      held_c  = out_carry;
      accepted = in_valid & in_ready;
      if (accepted) begin
        ref_model(in_data, int'(in_amt), in_op, r, c);
        e.data = r;
        e.carry = c;
        expq.push_back(e);
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (got !== n_words || expq.size() != 0 || extra != 0)
      $display("[TB] FAIL %s count: got %0d results (+%0d extra, %0d pending), expected %0d",
               name, got, extra, expq.size(), n_words);
    else passes++;
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b0, "stream_pattern");
  endtask

  task automatic test_random_stream();
    run_stream(40, 1'b1, "stream_random");
  endtask

  task automatic test_reset_midstream();
    int seen;
    logic [7:0] r;
    logic       c;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_amt   = 3'($urandom_range(1, 7));
      in_op    = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL midreset out_valid: got %b, expected 0", out_valid);
    else passes++;
    checks++;
    if (out_data !== 8'h00 || out_carry !== 1'b0)
      $display("[TB] FAIL midreset outputs: got %h/%b, expected 00/0", out_data, out_carry);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL midreset in_ready: got %b, expected 1", in_ready);
    else passes++;
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("[TB] FAIL midreset stale: got %0d valid cycles, expected 0", seen);
    else passes++;
    ref_model(8'h3C, 5, 2'd3, r, c);
    send_one(8'h3C, 3'd5, 2'd3, r, c, "post_reset");
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    $display("[TB] starting pipelined_barrel_shifter bench");
    test_reset();
    test_directed();
    test_amt_zero();
    test_random_single();
    test_back_to_back();
    test_random_stream();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
